// File: rtl/lcd_frame_checker.sv
// Read-side frame checker: drains the SDRAM read FIFO, rebuilds H_DISP x V_DISP frames
// and verifies each frame is one solid colour, keeping saturating mismatch statistics.
module lcd_frame_checker #(
    parameter int DATA_W = 16,
    parameter int H_DISP = 800,
    parameter int V_DISP = 480,
    parameter int ERR_W  = 16,
    parameter int FCNT_W = 16
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic              sdram_init_done,
    input  logic              rd_empty,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic [10:0]       pix_x,
    output logic [10:0]       pix_y,
    output logic [DATA_W-1:0] frame_color,
    output logic              frame_done,
    output logic              frame_ok,
    output logic              color_change,
    output logic [ERR_W-1:0]  frame_err,
    output logic [ERR_W-1:0]  err_total,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam logic [10:0] X_LAST = 11'(H_DISP - 1);
    localparam logic [10:0] Y_LAST = 11'(V_DISP - 1);

    typedef enum logic [0:0] {
        IDLE,
        RUN
    } state_t;

    state_t state, state_nxt;

    logic              rd_vld;
    logic [DATA_W-1:0] ref_color;

    logic              pix_take;
    logic              is_first;
    logic              is_last;
    logic              mismatch;
    logic [DATA_W-1:0] ref_now;
    logic [ERR_W-1:0]  frame_err_nxt;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            IDLE: if (sdram_init_done) state_nxt = RUN;
            RUN: begin
                if (!sdram_init_done) state_nxt = IDLE;
                else                  rd_en     = !rd_empty;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A pixel is accepted only while still running; a pop in flight when
    // sdram_init_done drops is thrown away.
    always_comb begin
        pix_take      = rd_vld && sdram_init_done && (state == RUN);
        is_first      = (pix_x == 11'd0) && (pix_y == 11'd0);
        is_last       = (pix_x == X_LAST) && (pix_y == Y_LAST);
        ref_now       = is_first ? rd_data : ref_color;
        mismatch      = !is_first && (rd_data != ref_color);
        frame_err_nxt = frame_err;
        if (mismatch && (frame_err != '1)) frame_err_nxt = frame_err + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld       <= 1'b0;
            ref_color    <= '0;
            pix_x        <= '0;
            pix_y        <= '0;
            frame_color  <= '0;
            frame_done   <= 1'b0;
            frame_ok     <= 1'b0;
            color_change <= 1'b0;
            frame_err    <= '0;
            err_total    <= '0;
            frame_cnt    <= '0;
        end else begin
            rd_vld       <= rd_en;
            frame_done   <= 1'b0;
            color_change <= 1'b0;

            if (!sdram_init_done || (state == IDLE)) begin
                pix_x     <= '0;
                pix_y     <= '0;
                frame_err <= '0;
            end else if (pix_take) begin
                if (is_first) ref_color <= rd_data;

                if (mismatch && (err_total != '1)) err_total <= err_total + 1'b1;

                if (is_last) begin
                    frame_done   <= 1'b1;
                    frame_ok     <= (frame_err_nxt == '0);
                    frame_color  <= ref_now;
                    frame_cnt    <= frame_cnt + 1'b1;
                    color_change <= (frame_cnt != '0) && (ref_now != frame_color);
                    frame_err    <= '0;
                end else begin
                    frame_err <= frame_err_nxt;
                end

                if (pix_x == X_LAST) begin
                    pix_x <= '0;
                    pix_y <= (pix_y == Y_LAST) ? 11'd0 : pix_y + 11'd1;
                end else begin
                    pix_x <= pix_x + 11'd1;
                end
            end
        end
    end

endmodule
